// File: rtl/bootrom_copy_engine.sv
// Bootrom copy engine: reads a block of 32-bit words from the bootrom reg-bus
// port and writes each one to a destination reg-bus port, one word in flight.
module bootrom_copy_engine #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   src_addr_i,
  input  logic [AddrWidth-1:0]   dst_addr_i,
  input  logic [CntWidth-1:0]    num_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   rd_valid_o,
  output logic [AddrWidth-1:0]   rd_addr_o,
  input  logic                   rd_ready_i,
  input  logic [DataWidth-1:0]   rd_rdata_i,
  input  logic                   rd_error_i,
  output logic                   wr_valid_o,
  output logic [AddrWidth-1:0]   wr_addr_o,
  output logic [DataWidth-1:0]   wr_wdata_o,
  output logic [DataWidth/8-1:0] wr_wstrb_o,
  input  logic                   wr_ready_i,
  input  logic                   wr_error_i
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FINISH
  } state_e;

  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);
  localparam logic [AddrWidth-1:0] Stride   = AddrWidth'(4);

  state_e               state_q, state_n;
  logic [AddrWidth-1:0] src_q, src_n;
  logic [AddrWidth-1:0] dst_q, dst_n;
  logic [DataWidth-1:0] wdata_q, wdata_n;
  logic [CntWidth-1:0]  cnt_q, cnt_n;
  logic                 err_q, err_n;
  logic                 rd_valid_q, rd_valid_n;
  logic                 wr_valid_q, wr_valid_n;
  logic                 done_q, done_n;
  logic                 busy_q, busy_n;

  // Next-state and datapath update; status/valid flags are decoded from the
  // next state so they come straight out of flops.
  always_comb begin
    state_n = state_q;
    src_n   = src_q;
    dst_n   = dst_q;
    wdata_n = wdata_q;
    cnt_n   = cnt_q;
    err_n   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_n = 1'b0;
          if (num_words_i == '0) begin
            state_n = FINISH;
          end else begin
            src_n   = src_addr_i & WordMask;
            dst_n   = dst_addr_i & WordMask;
            cnt_n   = num_words_i;
            state_n = READ;
          end
        end
      end
      READ: begin
        if (rd_ready_i) begin
          if (rd_error_i) begin
            err_n   = 1'b1;
            state_n = FINISH;
          end else begin
            wdata_n = rd_rdata_i;
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        if (wr_ready_i) begin
          if (wr_error_i) begin
            err_n   = 1'b1;
            state_n = FINISH;
          end else begin
            src_n   = src_q + Stride;
            dst_n   = dst_q + Stride;
            cnt_n   = cnt_q - CntWidth'(1);
            state_n = (cnt_q == CntWidth'(1)) ? FINISH : READ;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    rd_valid_n = (state_n == READ);
    wr_valid_n = (state_n == WRITE);
    done_n     = (state_n == FINISH);
    busy_n     = (state_n != IDLE);
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      src_q      <= src_n;
      dst_q      <= dst_n;
      wdata_q    <= wdata_n;
      cnt_q      <= cnt_n;
      err_q      <= err_n;
      rd_valid_q <= rd_valid_n;
      wr_valid_q <= wr_valid_n;
      done_q     <= done_n;
      busy_q     <= busy_n;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_addr_o  = src_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = dst_q;
  assign wr_wdata_o = wdata_q;
  assign wr_wstrb_o = '1;

endmodule

// File: tb/tb_bootrom_copy_engine.sv
// Self-checking bench for bootrom_copy_engine: transaction-level model of the
// expected read/write sequence with randomized responders.
module tb_bootrom_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy_o, done_o, err_o;
  logic        rd_valid_o, wr_valid_o;
  logic [31:0] rd_addr_o, wr_addr_o, wr_wdata_o;
  logic [3:0]  wr_wstrb_o;
  logic        rd_ready = 1'b0, rd_error = 1'b0;
  logic [31:0] rd_rdata = '0;
  logic        wr_ready = 1'b0, wr_error = 1'b0;

  bootrom_copy_engine #(
    .AddrWidth(32),
    .DataWidth(32),
    .CntWidth (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .src_addr_i (src_addr),
    .dst_addr_i (dst_addr),
    .num_words_i(num_words),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rd_valid_o (rd_valid_o),
    .rd_addr_o  (rd_addr_o),
    .rd_ready_i (rd_ready),
    .rd_rdata_i (rd_rdata),
    .rd_error_i (rd_error),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_wdata_o (wr_wdata_o),
    .wr_wstrb_o (wr_wstrb_o),
    .wr_ready_i (wr_ready),
    .wr_error_i (wr_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Job context shared by the driver and the responder/compare process.
  logic [31:0] exp_src, exp_dst, rom_seed;
  int          exp_n, exp_r, exp_w;
  logic        exp_e;
  bit          rom_simple = 1'b0;
  int          rd_cnt, wr_cnt, rd_stall, wr_stall;
  int          rd_min, rd_max, wr_min, wr_max;
  int          err_rd_idx, err_wr_idx;
  int          done_cnt, done_cyc, last_hs, busy_cycles, s_cyc;
  logic        prev_done = 1'b0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log_a[$];
  logic [31:0] wr_log_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (rom_simple) return 32'hA0 + (a >> 2);
    return (a * 32'h9E3779B1) ^ rom_seed;
  endfunction

  // Responders plus per-cycle compare against the expected transaction stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_ready  = 1'b0;
        wr_ready  = 1'b0;
        rd_error  = 1'b0;
        wr_error  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy_o) busy_cycles++;
        if (done_o) begin
          chk("done_one_cycle", 32'(prev_done), 0);
          done_cnt++;
          done_cyc = cyc;
        end
        prev_done = done_o;
        chk("no_overlap", 32'(rd_valid_o & wr_valid_o), 0);

        if (rd_valid_o) begin
          chk("rd_addr", rd_addr_o, exp_src + 32'(rd_cnt * 4));
          chk("rd_in_range", 32'(rd_cnt < exp_n), 1);
          chk("busy_in_rd", 32'(busy_o), 1);
          if (rd_stall == 0) begin
            rd_ready = 1'b1;
            rd_rdata = rom_word(rd_addr_o);
            rd_error = (rd_cnt == err_rd_idx);
            rd_log.push_back(rd_addr_o);
            rd_cnt++;
            last_hs  = cyc;
            rd_stall = $urandom_range(rd_max, rd_min);
          end else begin
            rd_ready = 1'b0;
            rd_rdata = $urandom;
            rd_error = 1'($urandom);
            rd_stall--;
          end
        end else begin
          rd_ready = 1'b0;
          rd_rdata = $urandom;
          rd_error = 1'($urandom);
        end

        if (wr_valid_o) begin
          chk("wr_addr", wr_addr_o, exp_dst + 32'(wr_cnt * 4));
          chk("wr_wdata", wr_wdata_o, rom_word(exp_src + 32'(wr_cnt * 4)));
          chk("wr_after_rd", 32'(wr_cnt < rd_cnt), 1);
          chk("wr_wstrb", 32'(wr_wstrb_o), 32'hF);
          if (wr_stall == 0) begin
            wr_ready = 1'b1;
            wr_error = (wr_cnt == err_wr_idx);
            wr_log_a.push_back(wr_addr_o);
            wr_log_d.push_back(wr_wdata_o);
            wr_cnt++;
            last_hs  = cyc;
            wr_stall = $urandom_range(wr_max, wr_min);
          end else begin
            wr_ready = 1'b0;
            wr_error = 1'($urandom);
            wr_stall--;
          end
        end else begin
          wr_ready = 1'b0;
          wr_error = 1'($urandom);
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input int n,
                           input int rmin, input int rmax, input int wmin, input int wmax,
                           input int erd, input int ewr);
    @(posedge clk); #1;
    exp_src = src & ~32'd3;
    exp_dst = dst & ~32'd3;
    exp_n   = n;
    rd_min = rmin; rd_max = rmax; wr_min = wmin; wr_max = wmax;
    rd_stall = $urandom_range(rmax, rmin);
    wr_stall = $urandom_range(wmax, wmin);
    err_rd_idx = erd;
    err_wr_idx = ewr;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cycles = 0; last_hs = -1;
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete();
    // Whichever error comes first in read/write order ends the copy.
    if (n == 0) begin
      exp_r = 0; exp_w = 0; exp_e = 1'b0;
    end else if (erd >= 0 && erd < n && (ewr < 0 || erd <= ewr)) begin
      exp_r = erd + 1; exp_w = erd; exp_e = 1'b1;
    end else if (ewr >= 0 && ewr < n) begin
      exp_r = ewr + 1; exp_w = ewr + 1; exp_e = 1'b1;
    end else begin
      exp_r = n; exp_w = n; exp_e = 1'b0;
    end
    start = 1'b1; src_addr = src; dst_addr = dst; num_words = 16'(n);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; num_words = 16'($urandom);
    chk("err_clear_on_start", 32'(err_o), 0);
    chk("busy_after_start", 32'(busy_o), 1);
  endtask

  task automatic finish_job();
    int t = 0;
    while (done_cnt == 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_seen", 32'(done_cnt != 0), 1);
    if (done_cnt == 0) return;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_rd_valid", 32'(rd_valid_o), 0);
    chk("idle_wr_valid", 32'(wr_valid_o), 0);
    chk("final_err", 32'(err_o), 32'(exp_e));
    chk("read_count", rd_cnt, exp_r);
    chk("write_count", wr_cnt, exp_w);
    if (exp_r == 0) chk("done_cycle", done_cyc, s_cyc + 1);
    else            chk("done_cycle", done_cyc, last_hs + 1);
    chk("busy_cycles", busy_cycles, done_cyc - s_cyc);
    @(posedge clk); #1;
    chk("single_done", done_cnt, 1);
  endtask

  initial begin
    int t;
    rom_seed = $urandom;
    exp_n = 0; rd_cnt = 0; wr_cnt = 0; err_rd_idx = -1; err_wr_idx = -1;
    rd_min = 0; rd_max = 0; wr_min = 0; wr_max = 0; rd_stall = 0; wr_stall = 0;
    done_cnt = 0; exp_src = '0; exp_dst = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_rd_valid", 32'(rd_valid_o), 0);
    chk("rst_wr_valid", 32'(wr_valid_o), 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_wdata", wr_wdata_o, 0);
    rst = 1'b0;

    // Zero-wait copy of four words
    rom_simple = 1'b1;
    start_job(32'h0000_0000, 32'h2000_0000, 4, 0, 0, 0, 0, -1, -1);
    finish_job();
    chk("t1_done_latency", done_cyc - s_cyc, 9);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wr_addr", wr_log_a[i], 32'h2000_0000 + 32'(i * 4));
      chk("t1_wr_data", wr_log_d[i], 32'hA0 + 32'(i));
    end
    rom_simple = 1'b0;

    // Backpressure: read waits 3, write waits 2
    start_job(32'h0000_1000, 32'h3000_0000, 2, 3, 3, 2, 2, -1, -1);
    finish_job();
    chk("t2_done_latency", done_cyc - s_cyc, 15);

    // Read error on word 2 of 3
    start_job(32'h0000_0040, 32'h2000_0100, 3, 0, 1, 0, 1, 1, -1);
    finish_job();
    chk("t3_err_held", 32'(err_o), 1);

    // Zero-length start (also clears the sticky error)
    start_job(32'h0000_0080, 32'h2000_0200, 0, 0, 0, 0, 0, -1, -1);
    finish_job();
    chk("t4_busy_one_cycle", busy_cycles, 1);
    chk("t4_done_latency", done_cyc - s_cyc, 1);

    // Source address wrap
    start_job(32'hFFFF_FFFC, 32'h2000_0300, 2, 0, 0, 0, 0, -1, -1);
    finish_job();
    chk("t5_rd_addr0", rd_log[0], 32'hFFFF_FFFC);
    chk("t5_rd_addr1", rd_log[1], 32'h0000_0000);

    // Write error on the first word
    start_job(32'h0000_0200, 32'h2000_0400, 3, 0, 2, 0, 2, -1, 0);
    finish_job();

    // Mid-copy start ignored, then reset during the second write
    start_job(32'h0000_0100, 32'h0000_3000, 4, 0, 0, 3, 3, -1, -1);
    start = 1'b1; src_addr = 32'h5555_0000; dst_addr = 32'h6666_0000; num_words = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!(wr_valid_o && wr_cnt == 1) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t6_second_write_pending", 32'(wr_valid_o && wr_cnt == 1), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rd_valid", 32'(rd_valid_o), 0);
    chk("t6_async_wr_valid", 32'(wr_valid_o), 0);
    chk("t6_async_busy", 32'(busy_o), 0);
    chk("t6_async_done", 32'(done_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_idle_busy", 32'(busy_o), 0);
    chk("t6_idle_rd_valid", 32'(rd_valid_o), 0);

    // Randomized jobs with random waits and error injection
    for (int j = 0; j < 30; j++) begin
      int n, erd, ewr;
      n   = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(10, 1));
      erd = ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 0)) : -1;
      ewr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 0)) : -1;
      start_job($urandom, $urandom, n, 0, int'($urandom_range(3, 0)),
                0, int'($urandom_range(3, 0)), erd, ewr);
      finish_job();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bootrom_copy_engine.md
Name: bootrom_copy_engine

Overview:
- Register-interface initiator that fetches a block of 32-bit words from the bootrom subsystem, which acts as the responder, and writes each word to a destination responder, e.g. an SRAM register port.
- Sits between the boot controller, which supplies start, source, destination and length, and two reg-bus ports: a read port toward the bootrom and a write port toward the destination.
- One word is in flight at a time; strictly sequential read-then-write.

Parameters:
- AddrWidth, 32, width of source/destination addresses and of both bus address ports.
- DataWidth, 32, bus data width; must be 32. Address stride per word is 4.
- CntWidth, 16, width of the word-count input and the internal counter.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  single-cycle start pulse, sampled in IDLE only
- src_addr_i  input  AddrWidth  source byte address, word aligned; bits [1:0] ignored
- dst_addr_i  input  AddrWidth  destination byte address, word aligned; bits [1:0] ignored
- num_words_i  input  CntWidth  number of words to copy
- busy_o  output  1  high while a copy is in progress
- done_o  output  1  one-cycle pulse at the end of a copy (success or error)
- err_o  output  1  sticky error flag; cleared on the next accepted start
- rd_valid_o  output  1  read request valid
- rd_addr_o  output  AddrWidth  read address
- rd_ready_i  input  1  responder ready; read data valid in the same cycle
- rd_rdata_i  input  DataWidth  read data
- rd_error_i  input  1  read error, valid when rd_ready_i is high
- wr_valid_o  output  1  write request valid
- wr_addr_o  output  AddrWidth  write address
- wr_wdata_o  output  DataWidth  write data
- wr_wstrb_o  output  DataWidth/8  write strobe; always all ones
- wr_ready_i  input  1  write accepted
- wr_error_i  input  1  write error, valid when wr_ready_i is high

Behaviour:
- Reset (rst_i high, asynchronous):
  - state returns to IDLE.
  - busy_o, done_o, err_o, rd_valid_o and wr_valid_o are 0.
  - Addresses, wdata and counter are 0.
  - Reset mid-transfer drops any valid immediately; no completion is signalled.
- Handshake, both ports:
  - valid, addr and wdata are registered and held stable until the cycle ready is high.
  - A transfer completes in the cycle valid && ready.
  - valid deasserts in the following cycle unless the next request of the same port starts.
  - Read and write never overlap.
- FSM states: IDLE, READ, WRITE, FINISH.
- IDLE:
  - On start_i with num_words_i == 0: go to FINISH with err_o cleared. No bus activity.
  - On start_i with num_words_i != 0:
    - latch src/dst (word aligned) and the count;
    - clear err_o;
    - go to READ with rd_valid_o=1 in the next cycle.
- READ:
  - Hold rd_valid_o until rd_ready_i.
  - On ready with rd_error_i=1: set err_o and go to FINISH. No write is issued.
  - On ready without error: capture rd_rdata_i into wr_wdata_o and go to WRITE with wr_valid_o=1 in the next cycle.
- WRITE:
  - Hold wr_valid_o until wr_ready_i.
  - On ready with wr_error_i=1: set err_o and go to FINISH.
  - On ready without error:
    - add 4 to src and dst (modulo 2^AddrWidth; wrap is silent);
    - decrement the count;
    - if the count reaches 0, go to FINISH, else go to READ.
- FINISH: done_o=1 for exactly one cycle, then IDLE.
- busy_o: high in READ, WRITE and FINISH.
- start_i while not in IDLE is ignored. The input buses are sampled only on an accepted start.
- Minimum latency per word is 2 cycles with zero-wait responders. An N-word copy with zero-wait responders has done_o in cycle 2N+1 after the start cycle.
- Count is CntWidth bits: maximum copy is 2^CntWidth-1 words.

Test Plan:
- Zero-wait copy: src=0x0000_0000, dst=0x2000_0000, n=4, bootrom words 0xA0..0xA3.
  -> writes to 0x2000_0000..0x2000_000C carry 0xA0..0xA3; done_o at cycle 9; err_o=0.
- Backpressure: rd_ready_i delayed 3 cycles, wr_ready_i delayed 2 cycles, n=2.
  -> rd_addr_o and wr_addr_o/wr_wdata_o stay stable while waiting; exactly 2 reads and 2 writes occur.
- Read error on word 2 of n=3.
  -> exactly 1 write; err_o=1; done_o pulses; a new start clears err_o.
- n=0 start.
  -> no valid ever asserted; done_o pulses the cycle after start; busy_o high for 1 cycle.
- Address wrap: src=0xFFFF_FFFC, n=2.
  -> read addresses are 0xFFFF_FFFC then 0x0000_0000.
- start_i pulsed mid-copy, then rst_i asserted during WRITE.
  -> the mid-copy start has no effect; on reset, valids and busy_o drop to 0 asynchronously and done_o is never asserted.
